// File: rtl/usb_data_buffer_pkg.sv
// ============================================================================
//  Module   : usb_buf_pkg
//  Purpose  : Shared constants and types for the USB shared byte FIFO.
//             BUF_DEPTH entries (power of two), pointer width PTR_W,
//             occupancy width OCC_W (holds 0..BUF_DEPTH inclusive).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package usb_buf_pkg;
  localparam int BUF_DEPTH = 64;
  localparam int PTR_W     = 6;
  localparam int OCC_W     = 7;

  typedef logic [7:0] usb_byte_t;
endpackage

`default_nettype wire

// File: rtl/usb_data_buffer_if.sv
// ============================================================================
//  Interface: usb_data_buffer_if
//  Purpose  : Bundles the push/pop/flush handshake and data bus between the
//             shared byte FIFO and its neighbours (RX engine, TX engine, AHB).
//  Modports : slave  - the FIFO (consumes requests, drives data/occupancy)
//             master - the environment (drives requests and push bytes)
//  Config   : USB_BUF_ERR_FLAGS_EN adds the sticky buf_error signal.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface usb_data_buffer_if;
  import usb_buf_pkg::*;

  logic             flush;
  logic             clear;
  logic             store_rx_packet_data;
  usb_byte_t        rx_packet_data;
  logic             store_tx_data;
  usb_byte_t        tx_data;
  logic             get_rx_data;
  usb_byte_t        rx_data;
  logic             get_tx_packet_data;
  usb_byte_t        tx_packet_data;
  logic [OCC_W-1:0] buffer_occupancy;
`ifdef USB_BUF_ERR_FLAGS_EN
  logic             buf_error;
`endif

  modport slave (
`ifdef USB_BUF_ERR_FLAGS_EN
    output buf_error,
`endif
    input  flush, clear,
    input  store_rx_packet_data, rx_packet_data,
    input  store_tx_data, tx_data,
    input  get_rx_data, get_tx_packet_data,
    output rx_data, tx_packet_data, buffer_occupancy
  );

  modport master (
`ifdef USB_BUF_ERR_FLAGS_EN
    input  buf_error,
`endif
    output flush, clear,
    output store_rx_packet_data, rx_packet_data,
    output store_tx_data, tx_data,
    output get_rx_data, get_tx_packet_data,
    input  rx_data, tx_packet_data, buffer_occupancy
  );
endinterface

`default_nettype wire

// File: rtl/usb_data_buffer.sv
// ============================================================================
//  Module   : usb_data_buffer
//  Purpose  : 64-byte shared byte FIFO. RX engine pushes, AHB pops (rx_data);
//             AHB pushes, TX engine pops (tx_packet_data). Emptied by flush or
//             clear. Pop data appears one cycle after an accepted pop.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - usb_data_buffer_if.slave (requests, data, occupancy)
//  Config   : USB_BUF_ERR_FLAGS_EN - enables sticky bus.buf_error flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module usb_data_buffer
  import usb_buf_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst,
  usb_data_buffer_if.slave  bus
);

  usb_byte_t        mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  usb_byte_t        rx_data_q, tx_data_q;

  logic      flush_req, empty, full;
  logic      push_req, pop_req, push_ok, pop_ok, pop_to_tx;
  usb_byte_t push_byte;

  assign flush_req = bus.flush | bus.clear;
  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OCC_W'(BUF_DEPTH));

  // RX-engine push wins over AHB push; TX-engine pop wins over AHB pop.
  assign push_req  = bus.store_rx_packet_data | bus.store_tx_data;
  assign push_byte = bus.store_rx_packet_data ? bus.rx_packet_data : bus.tx_data;
  assign pop_req   = bus.get_tx_packet_data | bus.get_rx_data;
  assign pop_to_tx = bus.get_tx_packet_data;

  // A full FIFO still accepts a push when a pop frees the head slot the same
  // cycle (full implies non-empty, so that pop is always accepted).
  assign pop_ok  = !flush_req && pop_req && !empty;
  assign push_ok = !flush_req && push_req && (!full || pop_req);

  always_comb begin
    occ_d = occ_q;
    if (push_ok && !pop_ok)
      occ_d = occ_q + OCC_W'(1);
    else if (pop_ok && !push_ok)
      occ_d = occ_q - OCC_W'(1);
  end

  // Storage is not reset; only written on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_q] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      rx_data_q <= '0;
      tx_data_q <= '0;
    end else if (flush_req) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        // Old head is read before a same-cycle write lands at a full FIFO.
        if (pop_to_tx)
          tx_data_q <= mem[rd_ptr_q];
        else
          rx_data_q <= mem[rd_ptr_q];
      end
      occ_q <= occ_d;
    end
  end

  assign bus.rx_data          = rx_data_q;
  assign bus.tx_packet_data   = tx_data_q;
  assign bus.buffer_occupancy = occ_q;

`ifdef USB_BUF_ERR_FLAGS_EN
  logic buf_error_q;
  logic err_event;

  // Dropped push (arbitration loser or full without pop) or ignored pop
  // (arbitration loser or empty). Suppressed during flush/clear.
  assign err_event = !flush_req &&
                     ((bus.store_rx_packet_data && bus.store_tx_data) ||
                      (bus.get_rx_data && bus.get_tx_packet_data)     ||
                      (push_req && !push_ok)                          ||
                      (pop_req && !pop_ok));

  always_ff @(posedge clk) begin
    if (rst || flush_req)
      buf_error_q <= 1'b0;
    else if (err_event)
      buf_error_q <= 1'b1;
  end

  assign bus.buf_error = buf_error_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_usb_data_buffer.sv
// ============================================================================
//  Module   : tb_usb_data_buffer
//  Purpose  : Self-checking bench for usb_data_buffer using a queue-based
//             reference model of the shared byte FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_usb_data_buffer;
  import usb_buf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_data_buffer_if bus();

  usb_data_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  usb_byte_t mq[$];
  usb_byte_t m_rx, m_tx;
  logic      m_err;

  task automatic idle();
    rst = 1'b0;
    bus.flush = 1'b0; bus.clear = 1'b0;
    bus.store_rx_packet_data = 1'b0; bus.rx_packet_data = 8'h00;
    bus.store_tx_data = 1'b0; bus.tx_data = 8'h00;
    bus.get_rx_data = 1'b0; bus.get_tx_packet_data = 1'b0;
  endtask

  // Behavioural FIFO rules applied to the inputs present at the clock edge.
  task automatic model_step();
    logic      push, pop, pop_ok, push_ok;
    usb_byte_t b, h;
    if (rst) begin
      mq.delete(); m_rx = 8'h00; m_tx = 8'h00; m_err = 1'b0;
    end else if (bus.flush || bus.clear) begin
      mq.delete(); m_err = 1'b0;
    end else begin
      push = bus.store_rx_packet_data || bus.store_tx_data;
      pop  = bus.get_rx_data || bus.get_tx_packet_data;
      b    = bus.store_rx_packet_data ? bus.rx_packet_data : bus.tx_data;
      pop_ok  = pop && (mq.size() > 0);
      push_ok = push && ((mq.size() < BUF_DEPTH) || pop_ok);
      if ((bus.store_rx_packet_data && bus.store_tx_data) ||
          (bus.get_rx_data && bus.get_tx_packet_data) ||
          (push && !push_ok) || (pop && !pop_ok))
        m_err = 1'b1;
      if (pop_ok) begin
        h = mq.pop_front();
        if (bus.get_tx_packet_data) m_tx = h; else m_rx = h;
      end
      if (push_ok) mq.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [OCC_W-1:0] m_occ();
    return OCC_W'(mq.size());
  endfunction

  task automatic test_reset();
    idle(); rst = 1'b1;
    tick(); tick();
    n_chk++; if (bus.buffer_occupancy !== 7'd0) begin n_fail++;
      $display("FAIL reset_occ: got %0d expected 0", bus.buffer_occupancy); end
    n_chk++; if (bus.rx_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_rx: got %h expected 00", bus.rx_data); end
    n_chk++; if (bus.tx_packet_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_tx: got %h expected 00", bus.tx_packet_data); end
`ifdef USB_BUF_ERR_FLAGS_EN
    n_chk++; if (bus.buf_error !== 1'b0) begin n_fail++;
      $display("FAIL reset_err: got %b expected 0", bus.buf_error); end
`endif
    idle();
  endtask

  task automatic test_rx_push_pop();
    logic [OCC_W-1:0] exp_occ [4] = '{7'd1, 7'd2, 7'd1, 7'd0};
    usb_byte_t        exp_rx  [2] = '{8'hA5, 8'h5A};
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i < 2) begin
        bus.store_rx_packet_data = 1'b1;
        bus.rx_packet_data = (i == 0) ? 8'hA5 : 8'h5A;
      end else begin
        bus.get_rx_data = 1'b1;
      end
      tick();
      n_chk++; if (bus.buffer_occupancy !== exp_occ[i]) begin n_fail++;
        $display("FAIL rxpp_occ[%0d]: got %0d expected %0d", i, bus.buffer_occupancy, exp_occ[i]); end
      if (i >= 2) begin
        n_chk++; if (bus.rx_data !== exp_rx[i-2]) begin n_fail++;
          $display("FAIL rxpp_data[%0d]: got %h expected %h", i, bus.rx_data, exp_rx[i-2]); end
      end
    end
    idle();
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < BUF_DEPTH + 1; i++) begin
      idle(); bus.store_tx_data = 1'b1; bus.tx_data = 8'($urandom);
      tick();
    end
    idle();
    n_chk++; if (bus.buffer_occupancy !== 7'd64) begin n_fail++;
      $display("FAIL fill_occ: got %0d expected 64", bus.buffer_occupancy); end
`ifdef USB_BUF_ERR_FLAGS_EN
    n_chk++; if (bus.buf_error !== 1'b1) begin n_fail++;
      $display("FAIL fill_err: got %b expected 1", bus.buf_error); end
`endif
    for (int i = 0; i < BUF_DEPTH; i++) begin
      idle(); bus.get_tx_packet_data = 1'b1;
      tick();
      n_chk++; if (bus.tx_packet_data !== m_tx || bus.buffer_occupancy !== m_occ()) begin n_fail++;
        $display("FAIL drain[%0d]: got %h/%0d expected %h/%0d", i, bus.tx_packet_data,
                 bus.buffer_occupancy, m_tx, m_occ()); end
    end
    idle();
  endtask

  task automatic test_flush();
    usb_byte_t rx0, tx0;
    idle(); bus.clear = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      idle(); bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'($urandom); tick();
    end
    rx0 = m_rx; tx0 = m_tx;
    idle(); bus.flush = 1'b1; bus.store_tx_data = 1'b1; bus.tx_data = 8'hEE;
    bus.get_rx_data = 1'b1;
    tick();
    n_chk++; if (bus.buffer_occupancy !== 7'd0) begin n_fail++;
      $display("FAIL flush_occ: got %0d expected 0", bus.buffer_occupancy); end
    n_chk++; if (bus.rx_data !== rx0 || bus.tx_packet_data !== tx0) begin n_fail++;
      $display("FAIL flush_hold: got %h/%h expected %h/%h", bus.rx_data, bus.tx_packet_data, rx0, tx0); end
`ifdef USB_BUF_ERR_FLAGS_EN
    n_chk++; if (bus.buf_error !== 1'b0) begin n_fail++;
      $display("FAIL flush_err: got %b expected 0", bus.buf_error); end
`endif
    idle(); bus.get_rx_data = 1'b1; tick();
    n_chk++; if (bus.buffer_occupancy !== 7'd0 || bus.rx_data !== rx0) begin n_fail++;
      $display("FAIL flush_get: got %0d/%h expected 0/%h", bus.buffer_occupancy, bus.rx_data, rx0); end
    idle();
  endtask

  task automatic test_empty_full_corner();
    usb_byte_t rx0;
    idle(); bus.clear = 1'b1; tick();
    rx0 = m_rx;
    idle(); bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h11;
    bus.get_rx_data = 1'b1; tick();
    n_chk++; if (bus.buffer_occupancy !== 7'd1 || bus.rx_data !== rx0) begin n_fail++;
      $display("FAIL empty_pp: got %0d/%h expected 1/%h", bus.buffer_occupancy, bus.rx_data, rx0); end
    for (int i = 0; i < BUF_DEPTH - 1; i++) begin
      idle(); bus.store_tx_data = 1'b1; bus.tx_data = 8'($urandom); tick();
    end
    idle(); bus.store_tx_data = 1'b1; bus.tx_data = 8'h77; bus.get_tx_packet_data = 1'b1;
    tick();
    n_chk++; if (bus.buffer_occupancy !== 7'd64 || bus.tx_packet_data !== 8'h11) begin n_fail++;
      $display("FAIL full_pp: got %0d/%h expected 64/11", bus.buffer_occupancy, bus.tx_packet_data); end
    idle();
  endtask

  task automatic test_arbitration();
    usb_byte_t rx0;
    idle(); bus.clear = 1'b1; tick();
    idle(); bus.store_tx_data = 1'b1; bus.tx_data = 8'h44; tick();
    idle(); bus.store_tx_data = 1'b1; bus.tx_data = 8'h55; tick();
    rx0 = m_rx;
    idle();
    bus.store_rx_packet_data = 1'b1; bus.rx_packet_data = 8'h22;
    bus.store_tx_data = 1'b1; bus.tx_data = 8'h33;
    bus.get_rx_data = 1'b1; bus.get_tx_packet_data = 1'b1;
    tick();
    n_chk++; if (bus.buffer_occupancy !== 7'd2 || bus.tx_packet_data !== 8'h44 || bus.rx_data !== rx0) begin
      n_fail++;
      $display("FAIL arb: got %0d/%h/%h expected 2/44/%h", bus.buffer_occupancy,
               bus.tx_packet_data, bus.rx_data, rx0); end
`ifdef USB_BUF_ERR_FLAGS_EN
    n_chk++; if (bus.buf_error !== 1'b1) begin n_fail++;
      $display("FAIL arb_err: got %b expected 1", bus.buf_error); end
`endif
    idle(); bus.get_tx_packet_data = 1'b1; tick();
    idle(); bus.get_tx_packet_data = 1'b1; tick();
    n_chk++; if (bus.tx_packet_data !== 8'h22) begin n_fail++;
      $display("FAIL arb_winner: got %h expected 22", bus.tx_packet_data); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      idle();
      rst       = ($urandom_range(0, 199) == 0);
      bus.flush = ($urandom_range(0, 59) == 0);
      bus.clear = ($urandom_range(0, 59) == 0);
      bus.store_rx_packet_data = ($urandom_range(0, 2) == 0);
      bus.store_tx_data        = ($urandom_range(0, 2) == 0);
      bus.rx_packet_data       = 8'($urandom);
      bus.tx_data              = 8'($urandom);
      // Bias toward pushes early so the FIFO reaches both empty and full.
      bus.get_rx_data        = ($urandom_range(0, (i % 200 < 100) ? 9 : 2) == 0);
      bus.get_tx_packet_data = ($urandom_range(0, (i % 200 < 100) ? 9 : 2) == 0);
      tick();
      n_chk++;
      if (bus.buffer_occupancy !== m_occ() || bus.rx_data !== m_rx || bus.tx_packet_data !== m_tx) begin
        n_fail++;
        $display("FAIL rand[%0d]: got occ=%0d rx=%h tx=%h expected occ=%0d rx=%h tx=%h", i,
                 bus.buffer_occupancy, bus.rx_data, bus.tx_packet_data, m_occ(), m_rx, m_tx);
      end
`ifdef USB_BUF_ERR_FLAGS_EN
      n_chk++; if (bus.buf_error !== m_err) begin n_fail++;
        $display("FAIL rand_err[%0d]: got %b expected %b", i, bus.buf_error, m_err); end
`endif
    end
    idle();
  endtask

  initial begin
    m_rx = 8'h00; m_tx = 8'h00; m_err = 1'b0;
    idle();
    test_reset();
    test_rx_push_pop();
    test_fill_wrap();
    test_flush();
    test_empty_full_corner();
    test_arbitration();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
